pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 8 +
 rtl/pipe_entry_reg.sv | 38 +++
 rtl/pipe_stage_reg.sv | 99 +++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared pipeline state encoding and default widths
package pipe_stage_reg_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    localparam int WORD_W     = 32;
    localparam int REG_W      = 5;
    localparam int CTRL_W_DEF = 2;
    localparam int DATA_W_DEF = 2 * WORD_W + REG_W;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: valid+ctrl+data register; clear zeroes valid/ctrl but keeps data
module pipe_entry_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end
    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage (SKID=1 two-entry, SKID=0 single-entry)
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);
    state_t            r_state, w_next;
    logic              r_in_ready;
    logic              w_acc, w_pop;
    logic              w_head_load, w_head_clear, w_skid_load, w_skid_clear;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    assign in_ready = !rst && (SKID ? r_in_ready : (!out_valid || out_ready));
    assign w_acc    = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;
    assign count    = (r_state == FULL) ? 2'd2 : (r_state == ONE) ? 2'd1 : 2'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != FULL);
        end
    end
    always_comb begin
        w_next       = r_state;
        w_head_load  = 1'b0;
        w_head_clear = flush;
        w_skid_load  = 1'b0;
        w_skid_clear = flush;
        if (flush) w_next = EMPTY;
        else begin
            case (r_state)
                EMPTY: begin
                    w_head_load = w_acc;
                    w_next      = w_acc ? ONE : EMPTY;
                end
                ONE: begin
                    w_head_load  = w_acc && w_pop;
                    w_skid_load  = w_acc && !w_pop;
                    w_head_clear = w_pop && !w_acc;
                    w_next       = (w_acc && !w_pop) ? FULL : (w_pop && !w_acc) ? EMPTY : ONE;
                end
                FULL: begin
                    w_head_load  = w_pop;
                    w_skid_clear = w_pop;
                    w_next       = w_pop ? ONE : FULL;
                end
                default: w_next = EMPTY;
            endcase
        end
    end
    // a pop from FULL promotes the skid entry into the head
    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_head_load),
        .i_clear (w_head_clear),
        .i_ctrl  (w_skid_valid ? w_skid_ctrl : in_ctrl),
        .i_data  (w_skid_valid ? w_skid_data : in_data),
        .o_valid (out_valid),
        .o_ctrl  (out_ctrl),
        .o_data  (out_data)
    );
    if (SKID) begin : g_skid
        pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_skid_load),
            .i_clear (w_skid_clear),
            .i_ctrl  (in_ctrl),
            .i_data  (in_data),
            .o_valid (w_skid_valid),
            .o_ctrl  (w_skid_ctrl),
            .o_data  (w_skid_data)
        );
    end else begin : g_noskid
        assign w_skid_valid = 1'b0;
        assign w_skid_ctrl  = '0;
        assign w_skid_data  = '0;
    end
endmodule
